// File: rtl/cordic_seq.sv
// -----------------------------------------------------------------------------
// cordic_seq -- sequential 8-bit CORDIC rotator (rotation mode).
//
// Rotates the signed vector (x_in, y_in) by the signed angle z_in, where
// 256 LSB is one full turn. The FSM runs IDLE -> PRE -> ITER (7 cycles) ->
// DONE -> IDLE. PRE folds angles beyond +/-90 deg into range, and ITER runs
// seven micro-rotations. All arithmetic is 8-bit two's complement that wraps
// modulo 256. There is no CORDIC gain compensation, so magnitudes grow by
// about 1.647.
//
// Ports
//   clk            : clock; all state changes happen on its rising edge
//   rst            : synchronous, active-high reset
//   start          : request a rotation; sampled only in IDLE
//   x_in, y_in     : signed input vector components
//   z_in           : signed rotation angle (64 = 90 deg)
//   busy           : high in PRE and ITER
//   done           : one-cycle pulse in DONE
//   x_out, y_out   : signed rotated vector, registered, held until next DONE
//   z_out          : signed residual angle, registered, held until next DONE
// -----------------------------------------------------------------------------
module cordic_seq (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic signed [7:0] x_in,
  input  logic signed [7:0] y_in,
  input  logic signed [7:0] z_in,
  output logic              busy,
  output logic              done,
  output logic signed [7:0] x_out,
  output logic signed [7:0] y_out,
  output logic signed [7:0] z_out
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PRE  = 2'd1,
    ITER = 2'd2,
    DONE = 2'd3
  } state_e;

  state_e            state_q;
  logic [2:0]        i_q;
  logic signed [7:0] x_q, y_q, z_q;
  logic signed [7:0] x_out_q, y_out_q, z_out_q;
  logic              busy_q, done_q;

  // Next values of the working registers for the PRE and ITER cycles.
  logic signed [7:0] x_pre_d, y_pre_d, z_pre_d;
  logic signed [7:0] x_it_d, y_it_d, z_it_d;
  logic signed [7:0] x_sh, y_sh, atan_val;
  logic              d_pos;

  // Arctangent table, in units of 1/256 turn.
  always_comb begin
    atan_val = 8'sd0;
    case (i_q)
      3'd0:    atan_val = 8'sd32;
      3'd1:    atan_val = 8'sd19;
      3'd2:    atan_val = 8'sd10;
      3'd3:    atan_val = 8'sd5;
      3'd4:    atan_val = 8'sd3;
      3'd5:    atan_val = 8'sd1;
      3'd6:    atan_val = 8'sd1;
      default: atan_val = 8'sd0;
    endcase
  end

  // NOTE: every signal written in this combinational block gets a default
  // first, so no path through it can leave a value held and infer a latch.
  always_comb begin
    // Quadrant correction. Negation is invert-plus-one in 8 bits, so
    // -(-128) wraps back to -128.
    x_pre_d = x_q;
    y_pre_d = y_q;
    z_pre_d = z_q;
    if (z_q >= 8'sd64) begin
      x_pre_d = ~y_q + 8'sd1;
      y_pre_d = x_q;
      z_pre_d = z_q - 8'sd64;
    end else if (z_q < -8'sd64) begin
      x_pre_d = y_q;
      y_pre_d = ~x_q + 8'sd1;
      z_pre_d = z_q + 8'sd64;
    end

    // One micro-rotation. The shifts are arithmetic because the operands are
    // signed. Both shifts read the values from before this update.
    d_pos = ~z_q[7];
    x_sh  = x_q >>> i_q;
    y_sh  = y_q >>> i_q;
    if (d_pos) begin
      x_it_d = x_q - y_sh;
      y_it_d = y_q + x_sh;
      z_it_d = z_q - atan_val;
    end else begin
      x_it_d = x_q + y_sh;
      y_it_d = y_q - x_sh;
      z_it_d = z_q + atan_val;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only. All registers
  // in the block then update together from their pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      i_q     <= 3'd0;
      x_q     <= 8'sd0;
      y_q     <= 8'sd0;
      z_q     <= 8'sd0;
      x_out_q <= 8'sd0;
      y_out_q <= 8'sd0;
      z_out_q <= 8'sd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            x_q     <= x_in;
            y_q     <= y_in;
            z_q     <= z_in;
            busy_q  <= 1'b1;
            state_q <= PRE;
          end
        end
        PRE: begin
          x_q     <= x_pre_d;
          y_q     <= y_pre_d;
          z_q     <= z_pre_d;
          i_q     <= 3'd0;
          state_q <= ITER;
        end
        ITER: begin
          x_q <= x_it_d;
          y_q <= y_it_d;
          z_q <= z_it_d;
          if (i_q == 3'd6) begin
            // The last step goes straight to the output registers, so the
            // results are valid in the same cycle that done is high.
            i_q     <= 3'd0;
            x_out_q <= x_it_d;
            y_out_q <= y_it_d;
            z_out_q <= z_it_d;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end else begin
            i_q <= i_q + 3'd1;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy  = busy_q;
  assign done  = done_q;
  assign x_out = x_out_q;
  assign y_out = y_out_q;
  assign z_out = z_out_q;

endmodule

// File: doc/cordic_seq.md
CORDIC_SEQ -- requirements
Module: cordic_seq

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-002 SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-003 SHALL have port start, input, 1 bit: request a rotation; sampled only in IDLE.
REQ-004 SHALL have ports x_in and y_in, input, 8 bits each: signed two's-complement vector components.
REQ-005 SHALL have port z_in, input, 8 bits: signed rotation angle; 256 LSB = one full turn (64 = 90 deg).
REQ-006 SHALL have port busy, output, 1 bit: high in PRE and ITER.
REQ-007 SHALL have port done, output, 1 bit: single-cycle pulse, high in DONE.
REQ-008 SHALL have ports x_out, y_out and z_out, output, 8 bits each: signed rotated vector and residual angle, registered.

Function
REQ-009 SHALL implement FSM IDLE -> PRE -> ITER -> DONE -> IDLE.
REQ-010 SHALL, in IDLE with start=1, latch x_in/y_in/z_in into the working registers and enter PRE next cycle; start=0 keeps IDLE.
REQ-011 SHALL, in PRE, apply quadrant correction in one cycle.
- z>=64: x<=-y, y<=x, z<=z-64.
- z<-64: x<=y, y<=-x, z<=z+64.
- Otherwise: registers unchanged.
Then enter ITER with i=0.
REQ-012 SHALL compute negation as bitwise invert plus one, modulo 256; -(-128) = -128 (wrap, no saturation).
REQ-013 SHALL, in ITER step i (0..6), set d=+1 if z>=0 and d=-1 otherwise, then update:
- x <= x - d*(y>>>i)
- y <= y + d*(x>>>i)
- z <= z - d*atan[i]
REQ-014 SHALL use >>> as an arithmetic (sign-filling, floor) shift of the pre-update values.
REQ-015 SHALL use atan table [32,19,10,5,3,1,1] for i=0..6.
REQ-016 SHALL perform all datapath arithmetic at 8 bits, wrapping modulo 256, with no saturation and no gain (K≈1.647) compensation.
REQ-017 SHALL leave ITER for DONE after step i=6, giving exactly 7 ITER cycles.
REQ-018 SHALL update x_out/y_out/z_out from the working registers on entry to DONE, and hold them until the next DONE.
REQ-019 SHALL assert done for exactly one cycle (the DONE cycle), then return to IDLE; total latency is 9 cycles from the start-sampling edge to the done-high cycle.
REQ-020 SHALL ignore start in PRE, ITER and DONE, with no queueing; a start held high through DONE is accepted in the following IDLE cycle.
REQ-021 SHALL keep the iteration counter within 0..6 with no wrap-around.

Reset
REQ-022 SHALL, with rst=1 at a clock edge, force:
- state=IDLE, i=0, busy=0, done=0;
- x_out=y_out=z_out=0;
- working registers=0.
REQ-023 SHALL give rst priority over start and over any in-progress operation; a rotation aborted mid-ITER produces no done and leaves the outputs at 0.

Verification
REQ-024 SHALL cover: x_in=60, y_in=0, z_in=0, start pulse -> done 9 cycles later; x_out=100, y_out=0, z_out=-1; busy high for 8 cycles.
REQ-025 SHALL cover: x_in=0, y_in=-60, z_in=64 -> PRE yields (60,0,0); outputs 100, 0, -1.
REQ-026 SHALL cover: x_in=0, y_in=-128, z_in=64 -> PRE x register = -128 (negation wrap); no X/hang; done after 9 cycles.
REQ-027 SHALL cover: start re-pulsed during ITER -> ignored; exactly one done; outputs match the first operands.
REQ-028 SHALL cover: rst asserted during ITER step 3 -> next cycle state IDLE, busy=0, outputs 0, no done pulse.
REQ-029 SHALL cover: start held high continuously -> back-to-back operations with done every 10 cycles; outputs stable between done pulses.
